// File: rtl/uart_hex_word_loader.sv
// Decodes an ASCII hex stream (MSB-first, either case) into WORD_W-bit words written through a
// synchronous memory port, echoing accepted bytes; `UART_HEX_LOADER_CHECKSUM_EN adds a '#' checksum reply.
module uart_hex_word_loader #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 0,
  parameter int ECHO   = 1,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic [7:0]        chk
);
  localparam int NIB   = WORD_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0]  LAST_DIG  = CNT_W'(NIB - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   WCNT_MAX  = (ADDR_W + 1)'(DEPTH);

  logic [WORD_W-1:0] shreg_q, mem_wdata_q, word_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [ADDR_W:0]   wcnt_q;
  logic              full_q, err_q, mem_we_q, tx_vld_q, live_q;
  logic [7:0]        tx_dat_q, cs_val_q;
  logic [1:0]        cs_pend_q;
  logic [3:0]        nib;
  logic              is_hex, is_ws, is_at, is_hash, acc, dec, restart, wr_fire;

  function automatic logic [7:0] hex_chr(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
  end

  assign is_ws    = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A) || (rx_data == 8'h09);
  assign is_at    = (rx_data == 8'h40);
  assign rx_ready = live_q && !tx_vld_q && (cs_pend_q == 2'd0);
  assign acc      = rx_valid && rx_ready;
  assign dec      = acc && load_en;
  assign restart  = dec && is_at;
  assign word_d   = (shreg_q << 4) | WORD_W'(nib);
  assign wr_fire  = dec && is_hex && (cnt_q == LAST_DIG) && !full_q;

`ifdef UART_HEX_LOADER_CHECKSUM_EN
  logic [7:0] chk_q, nib_sum;
  always_comb begin
    nib_sum = chk_q;
    for (int i = 0; i < NIB; i++) nib_sum = nib_sum + {4'h0, word_d[4*i +: 4]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       chk_q <= 8'h00;
    else if (restart) chk_q <= 8'h00;
    else if (wr_fire) chk_q <= nib_sum;
  end
  assign is_hash = (rx_data == 8'h23);
  assign chk     = chk_q;
`else
  assign is_hash = 1'b0;
  assign chk     = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wcnt_q      <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tx_vld_q    <= 1'b0;
      tx_dat_q    <= 8'h00;
      cs_val_q    <= 8'h00;
      cs_pend_q   <= 2'd0;
      live_q      <= 1'b0;
    end else begin
      live_q   <= 1'b1;
      mem_we_q <= 1'b0;
      if (tx_vld_q && tx_ready) tx_vld_q <= 1'b0;
      // The echo of '#' always precedes the two checksum characters.
      if (acc && (ECHO != 0)) begin
        tx_vld_q <= 1'b1;
        tx_dat_q <= rx_data;
      end else if ((cs_pend_q != 2'd0) && (!tx_vld_q || tx_ready)) begin
        tx_vld_q  <= 1'b1;
        tx_dat_q  <= (cs_pend_q == 2'd2) ? hex_chr(cs_val_q[7:4]) : hex_chr(cs_val_q[3:0]);
        cs_pend_q <= cs_pend_q - 2'd1;
      end
      if (!load_en) cnt_q <= '0;
      if (dec) begin
        if (is_hex) begin
          shreg_q <= word_d;
          if (cnt_q == LAST_DIG) begin
            cnt_q <= '0;
            if (!full_q) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= word_d;
              if (wcnt_q != WCNT_MAX) wcnt_q <= wcnt_q + 1'b1;
              if (addr_q != LAST_ADDR)  addr_q <= addr_q + 1'b1;
              else if (WRAP != 0)       addr_q <= '0;
              else                      full_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else if (is_at) begin
          shreg_q <= '0;
          cnt_q   <= '0;
          addr_q  <= '0;
          wcnt_q  <= '0;
          full_q  <= 1'b0;
          err_q   <= 1'b0;
        end else if (is_hash) begin
          cs_val_q  <= chk;
          cs_pend_q <= 2'd2;
        end else if (!is_ws) begin
          err_q <= 1'b1;
          cnt_q <= '0;
        end
      end
    end
  end

  assign tx_data    = tx_dat_q;
  assign tx_valid   = tx_vld_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = wcnt_q;
  assign full       = full_q;
  assign err        = err_q;
endmodule
